// File: rtl/eth_udp_pkg.sv
// Shared states and protocol constants for the GMII UDP/IPv4 receiver.
package eth_udp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_ETH_HDR,
    ST_IP_HDR,
    ST_UDP_HDR,
    ST_PAYLOAD,
    ST_TRAILER,
    ST_DROP
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [15:0] PREAMBLE_MAX  = 16'd7;
  localparam logic [7:0]  SFD           = 8'hD5;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam logic [15:0] ETH_HDR_LEN   = 16'd14;
  localparam logic [15:0] IP_HDR_LEN    = 16'd20;
  localparam logic [15:0] UDP_HDR_LEN   = 16'd8;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

endpackage

// File: rtl/crc32_d8.sv
// Combinational next state of the reflected Ethernet CRC-32 for one input byte.
module crc32_d8
  import eth_udp_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 8; i++) begin
      crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ data[i]) ? CRC_POLY : 32'h0);
    end
  end

endmodule

// File: rtl/eth_udp_rx_gmii.sv
// GMII UDP/IPv4 receiver: filters on MAC/IP/port and streams the payload.
// Define ETH_RX_CRC_CHECK_EN to make rx_done depend on a good FCS.
module eth_udp_rx_gmii
  import eth_udp_pkg::*;
#(
  parameter int PAYLOAD_MAX = 1472
) (
  input  logic        clk_125m,
  input  logic        rst,
  input  logic        gmii_rxdv,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rxer,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [15:0] local_port,
  output logic        payload_valid_o,
  output logic [7:0]  payload_dat_o,
  output logic [15:0] payload_len_o,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip,
  output logic [15:0] src_port,
  output logic        rx_done,
  output logic        rx_err
);

  localparam logic [16:0] LEN_MAX = 17'(PAYLOAD_MAX + 8);

  rx_state_e   state_reg;
  logic [15:0] cnt_reg;
  logic        armed_reg;
  logic [47:0] dst_mac_reg, src_mac_cap_reg;
  logic [7:0]  type_hi_reg;
  logic [31:0] src_ip_cap_reg, dst_ip_reg;
  logic [15:0] src_port_cap_reg, dst_port_reg, udp_len_reg;
  logic        crc_ok;
  logic        hdr_fault;
  rx_state_e   abort_state;

  assign hdr_fault   = !gmii_rxdv || gmii_rxer;
  assign abort_state = gmii_rxdv ? ST_DROP : ST_IDLE;

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc_reg, crc_next;

  crc32_d8 u_crc (
    .crc      (crc_reg),
    .data     (gmii_rxd),
    .crc_next (crc_next)
  );

  // Held at init through the preamble so the first MAC byte starts a fresh CRC.
  always_ff @(posedge clk_125m or posedge rst) begin
    if (rst)                            crc_reg <= CRC_INIT;
    else if (state_reg == ST_PREAMBLE)  crc_reg <= CRC_INIT;
    else if (gmii_rxdv)                 crc_reg <= crc_next;
  end

  assign crc_ok = (crc_reg == CRC_RESIDUE);
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge clk_125m or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      armed_reg        <= 1'b0;
      dst_mac_reg      <= '0;
      src_mac_cap_reg  <= '0;
      type_hi_reg      <= '0;
      src_ip_cap_reg   <= '0;
      dst_ip_reg       <= '0;
      src_port_cap_reg <= '0;
      dst_port_reg     <= '0;
      udp_len_reg      <= '0;
      payload_valid_o  <= 1'b0;
      payload_dat_o    <= '0;
      payload_len_o    <= '0;
      src_mac          <= '0;
      src_ip           <= '0;
      src_port         <= '0;
      rx_done          <= 1'b0;
      rx_err           <= 1'b0;
    end else begin
      payload_valid_o <= 1'b0;
      rx_done         <= 1'b0;
      rx_err          <= 1'b0;
      cnt_reg         <= cnt_reg + 16'd1;
      // A frame already running when reset lifted must pass before hunting.
      if (!gmii_rxdv) armed_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (gmii_rxdv && armed_reg) begin
            state_reg <= (gmii_rxd == PREAMBLE_BYTE && !gmii_rxer) ? ST_PREAMBLE : ST_DROP;
          end
        end

        ST_PREAMBLE: begin
          if (hdr_fault) begin
            state_reg <= abort_state;
            cnt_reg   <= '0;
          end else if (gmii_rxd == SFD) begin
            state_reg <= ST_ETH_HDR;
            cnt_reg   <= '0;
          end else if (gmii_rxd != PREAMBLE_BYTE || cnt_reg >= PREAMBLE_MAX - 16'd1) begin
            state_reg <= ST_DROP;
            cnt_reg   <= '0;
          end
        end

        ST_ETH_HDR: begin
          if (hdr_fault) begin
            state_reg <= abort_state;
            cnt_reg   <= '0;
          end else begin
            if (cnt_reg < 16'd6)       dst_mac_reg     <= {dst_mac_reg[39:0], gmii_rxd};
            else if (cnt_reg < 16'd12) src_mac_cap_reg <= {src_mac_cap_reg[39:0], gmii_rxd};
            else if (cnt_reg == 16'd12) type_hi_reg    <= gmii_rxd;
            if (cnt_reg == ETH_HDR_LEN - 16'd1) begin
              cnt_reg   <= '0;
              state_reg <= ((dst_mac_reg == local_mac || dst_mac_reg == BCAST_MAC) &&
                            {type_hi_reg, gmii_rxd} == ETH_TYPE_IPV4) ? ST_IP_HDR : ST_DROP;
            end
          end
        end

        ST_IP_HDR: begin
          if (hdr_fault) begin
            state_reg <= abort_state;
            cnt_reg   <= '0;
          end else begin
            if (cnt_reg >= 16'd12 && cnt_reg < 16'd16) src_ip_cap_reg <= {src_ip_cap_reg[23:0], gmii_rxd};
            else if (cnt_reg >= 16'd16)                dst_ip_reg     <= {dst_ip_reg[23:0], gmii_rxd};
            if ((cnt_reg == 16'd0 && gmii_rxd != IP_VER_IHL) ||
                (cnt_reg == 16'd9 && gmii_rxd != IP_PROTO_UDP)) begin
              state_reg <= ST_DROP;
              cnt_reg   <= '0;
            end else if (cnt_reg == IP_HDR_LEN - 16'd1) begin
              cnt_reg   <= '0;
              state_reg <= ({dst_ip_reg[23:0], gmii_rxd} == local_ip) ? ST_UDP_HDR : ST_DROP;
            end
          end
        end

        ST_UDP_HDR: begin
          if (hdr_fault) begin
            state_reg <= abort_state;
            cnt_reg   <= '0;
          end else begin
            if (cnt_reg < 16'd2)      src_port_cap_reg <= {src_port_cap_reg[7:0], gmii_rxd};
            else if (cnt_reg < 16'd4) dst_port_reg     <= {dst_port_reg[7:0], gmii_rxd};
            else if (cnt_reg < 16'd6) udp_len_reg      <= {udp_len_reg[7:0], gmii_rxd};
            if (cnt_reg == UDP_HDR_LEN - 16'd1) begin
              cnt_reg <= '0;
              if (dst_port_reg == local_port && udp_len_reg >= UDP_HDR_LEN &&
                  {1'b0, udp_len_reg} <= LEN_MAX) begin
                src_mac       <= src_mac_cap_reg;
                src_ip        <= src_ip_cap_reg;
                src_port      <= src_port_cap_reg;
                payload_len_o <= udp_len_reg - UDP_HDR_LEN;
                state_reg     <= (udp_len_reg == UDP_HDR_LEN) ? ST_TRAILER : ST_PAYLOAD;
              end else begin
                state_reg <= ST_DROP;
              end
            end
          end
        end

        ST_PAYLOAD: begin
          if (hdr_fault) begin
            rx_err    <= 1'b1;
            state_reg <= abort_state;
            cnt_reg   <= '0;
          end else begin
            payload_valid_o <= 1'b1;
            payload_dat_o   <= gmii_rxd;
            if (cnt_reg == payload_len_o - 16'd1) begin
              state_reg <= ST_TRAILER;
              cnt_reg   <= '0;
            end
          end
        end

        ST_TRAILER: begin
          if (!gmii_rxdv) begin
            rx_done   <= crc_ok;
            rx_err    <= !crc_ok;
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else if (gmii_rxer) begin
            rx_err    <= 1'b1;
            state_reg <= ST_DROP;
            cnt_reg   <= '0;
          end
        end

        ST_DROP: begin
          if (!gmii_rxdv) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end
        end

        default: begin
          state_reg <= ST_DROP;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule
